clk_divider_prog: RTL

Programmable integer clock divider. It sits directly downstream of the clock buffer and consumes the buffered master clock as its only clock. It produces a divided clock and a one-cycle rising-edge tick for slower stages. Divisor changes and stop requests take effect only at an output-period boundary, so the divider never emits a truncated or glitched period.

---
 rtl/clk_divider_prog.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/clk_divider_prog.sv
`default_nettype none
// ============================================================================
//  clk_divider_prog : programmable integer clock divider with tick output.
//  Revision: 1.0
// ============================================================================
module clk_divider_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [DIV_W-1:0] cur_div,
    output logic             load_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] C_DEFAULT_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] C_MIN_DIV     = DIV_W'(2);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             running_q, running_d;
    logic             load_err_q, load_err_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_valid_q, pend_valid_d;

    logic             load_legal;
    logic             period_start;
    logic [DIV_W-1:0] last_cnt;
    logic [DIV_W:0]   cnt_inc;
    logic [DIV_W:0]   half;

    assign load_legal = (div_val >= C_MIN_DIV);
    assign last_cnt   = cur_div_q - 1'b1;
    assign cnt_inc    = {1'b0, cnt_q} + 1'b1;
    // High phase length is ceil(N/2); one extra bit keeps N+1 from wrapping.
    assign half       = ({1'b0, cur_div_q} + 1'b1) >> 1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clk_out_d    = 1'b0;
        tick_d       = 1'b0;
        running_d    = running_q;
        cur_div_d    = cur_div_q;
        pend_div_d   = pend_div_q;
        pend_valid_d = pend_valid_q;
        period_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                running_d = 1'b0;
                if (en) begin
                    state_d      = ST_RUN;
                    running_d    = 1'b1;
                    clk_out_d    = 1'b1;
                    tick_d       = 1'b1;
                    period_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q != last_cnt) begin
                    cnt_d     = cnt_inc[DIV_W-1:0];
                    clk_out_d = (cnt_inc < half);
                end else if (en) begin
                    cnt_d        = '0;
                    clk_out_d    = 1'b1;
                    tick_d       = 1'b1;
                    period_start = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    running_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                running_d = 1'b0;
            end
        endcase

        // The boundary consumes the value pending before this edge; a load on
        // the same edge queues behind it for the following boundary.
        if (period_start && pend_valid_q) begin
            cur_div_d    = pend_div_q;
            pend_valid_d = 1'b0;
        end
        if (div_load && load_legal) begin
            pend_div_d   = div_val;
            pend_valid_d = 1'b1;
        end
        load_err_d = div_load && !load_legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            running_q    <= 1'b0;
            load_err_q   <= 1'b0;
            cur_div_q    <= C_DEFAULT_DIV;
            pend_div_q   <= C_DEFAULT_DIV;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            running_q    <= running_d;
            load_err_q   <= load_err_d;
            cur_div_q    <= cur_div_d;
            pend_div_q   <= pend_div_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign clk_out  = clk_out_q;
    assign tick     = tick_q;
    assign running  = running_q;
    assign cur_div  = cur_div_q;
    assign load_err = load_err_q;

endmodule
`default_nettype wire
